remus_block_sched: RTL and testbench
====================================

Name: remus_block_sched

Overview:
- Sequencer for the Remus mode datapath: one 128-bit state, one tweakey-X register, one SKINNY round function and block-counter doubling, all on a BUSWIDTH-bit bus.
- Accepts one command per block: associated data (AD), encrypt (ENC) or decrypt (DEC).
- Drives the datapath control strobes through load, rounds, counter correction and unload, with valid/ready handshakes on the input and output buses.
- Sits between the top-level I/O controller and the mode datapath. Does not touch data values.

Parameters:
- BUSWIDTH, 32, datapath bus width in bits; only 32 is supported.
- BUSWIDTHBYTE, 4, BUSWIDTH/8.
- ROUNDS, 40, SKINNY-128-384+ round count per block.
- BEATS, 128/BUSWIDTH, bus beats per 128-bit block.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_op  in  2  0=AD, 1=ENC, 2=DEC; 3 is reserved and treated as AD.
- cmd_first  in  1  first block of a message: clears state, tkx and block counter.
- cmd_nbytes  in  5  valid bytes in the block, 1..16.
- pdi_valid / pdi_ready  in / out  1  input-bus beat handshake.
- pdo_valid / pdo_ready  out / in  1  output-bus beat handshake.
- srst, senc, sse  out  1  state reset, enable, shift-select.
- xrst, xenc, xse  out  1  tkx reset, enable, shift-select.
- erst  out  1  round-constant init.
- sl  out  1  tkx loads from pdo (1) or sdi (0).
- correct_cnt  out  1  tkx counter-correction select.
- dold, dnew  out  8  current and next block-counter byte.
- decrypt  out  BUSWIDTHBYTE  per-byte decrypt mask for the current output beat.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state becomes IDLE; beat_cnt=0, rnd_cnt=0, blk_cnt=8'h01.
  - Outputs: srst=xrst=1, erst=1. All other strobes, valid/ready outputs, decrypt and busy are 0. dold=8'h01, dnew=8'h02.
  - rst overrides every state, including mid-round and mid-unload. Any partial block is discarded with no output.
- Counter: dold=blk_cnt; dnew=lfsr(blk_cnt) = {blk_cnt[6:0],1'b0} ^ (blk_cnt[7] ? 8'h1D : 8'h00).
- IDLE:
  - cmd_ready=1, erst=1.
  - On handshake, latch op, first and nbytes; go to LOAD.
  - If first=1: pulse srst=xrst=1 that cycle and set blk_cnt=8'h01.
- LOAD:
  - pdi_ready=1, erst=1.
  - Each pdi handshake: senc=sse=1 and xenc=xse=1 (shift in one beat), sl=0, beat_cnt+1.
  - No handshake means no enables.
  - After beat BEATS-1: go to ROUND, rnd_cnt=0.
- ROUND:
  - Exactly ROUNDS cycles; erst=0, senc=1, sse=0, xenc=1, xse=0.
  - rnd_cnt increments each cycle. When rnd_cnt==ROUNDS-1, go to FIX. Stalls are impossible here.
- FIX: one cycle.
  - correct_cnt=1, xenc=1, xse=0.
  - blk_cnt<=dnew.
  - If op==AD go to IDLE; otherwise go to OUT with beat_cnt=0.
- OUT:
  - pdo_valid=1, sl=1.
  - Each pdo handshake: senc=sse=1, beat_cnt+1.
  - decrypt[i]=1 iff op==DEC and byte (beat_cnt*BUSWIDTHBYTE+i) < nbytes.
  - pdo_valid holds, and strobes stay 0, while pdo_ready=0.
  - After beat BEATS-1: go to IDLE.
- cmd_ready=0 outside IDLE. A cmd_valid arriving during other states waits.
- AD block latency: BEATS + ROUNDS + 1 cycles after the last command handshake, with no stalls.
- nbytes=0 or >16 is clamped to 16.

Decomposition:
- Shared package:
  - state encoding: IDLE, LOAD, ROUND, FIX, OUT;
  - op codes;
  - LFSR polynomial constant 8'h1D;
  - ROUNDS default.
- One sub-module, remus_blkcnt_lfsr: the combinational dold→dnew step, reused by the bench model.

Test Plan:
1. Reset: hold rst 2 cycles → srst=xrst=erst=1, cmd_ready=0 during reset, dold=01, dnew=02. After release, cmd_ready=1 and busy=0.
2. ENC single block, first=1, pdi and pdo always ready → srst/xrst pulse on command cycle; 4 LOAD cycles; senc=1/sse=0 for exactly 40 cycles; correct_cnt high 1 cycle; 4 pdo beats; decrypt=0; cmd_ready returns at cycle 1+4+40+1+4=50.
3. DEC block, nbytes=6 → decrypt masks per beat 4'b1111, 4'b0011, 4'b0000, 4'b0000.
4. Back-to-back AD blocks from first → dold sequence 01,02,04,…,80,1D. No pdo_valid ever.
5. Backpressure: pdi_valid low 3 cycles mid-LOAD and pdo_ready low 5 cycles mid-OUT → no enables during gaps, beat count stays exactly 4, pdo_valid held high.
6. rst asserted at round 20 → next cycle IDLE, blk_cnt=01, no pdo_valid. A following ENC block completes normally.

Source files
------------

// File: rtl/remus_block_sched_pkg.sv
// Shared types and constants for the Remus block sequencer.
package remus_block_sched_pkg;

  localparam int unsigned BUSWIDTH_DEF = 32;
  localparam int unsigned ROUNDS_DEF   = 40;
  localparam int unsigned OP_W         = 2;
  localparam int unsigned NBYTES_W     = 5;
  localparam int unsigned BLOCK_BYTES  = 16;

  localparam logic [7:0] LFSR_POLY    = 8'h1D;
  localparam logic [7:0] BLK_CNT_INIT = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FIX   = 3'd3,
    ST_OUT   = 3'd4
  } sched_state_e;

  typedef enum logic [OP_W-1:0] {
    OP_AD   = 2'd0,
    OP_ENC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef struct packed {
    op_e                 op;
    logic [NBYTES_W-1:0] nbytes;
  } cmd_t;

  localparam cmd_t CMD_RESET = '{op: OP_AD, nbytes: '0};

  // Reserved opcode behaves as associated data.
  function automatic op_e decode_op(input logic [OP_W-1:0] raw);
    return (raw == OP_RSVD) ? OP_AD : op_e'(raw);
  endfunction

  // Out-of-range byte counts mean a full block.
  function automatic logic [NBYTES_W-1:0] clamp_nbytes(input logic [NBYTES_W-1:0] n);
    return ((n == '0) || (n > NBYTES_W'(BLOCK_BYTES))) ? NBYTES_W'(BLOCK_BYTES) : n;
  endfunction

endpackage

// File: rtl/remus_block_sched_if.sv
// Command, input-bus and output-bus handshakes between the I/O controller and the sequencer.
interface remus_block_sched_if;
  import remus_block_sched_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OP_W-1:0]     cmd_op;
  logic                cmd_first;
  logic [NBYTES_W-1:0] cmd_nbytes;
  logic                pdi_valid;
  logic                pdi_ready;
  logic                pdo_valid;
  logic                pdo_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_first, cmd_nbytes, pdi_valid, pdo_ready,
    input  cmd_ready, pdi_ready, pdo_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_first, cmd_nbytes, pdi_valid, pdo_ready,
    output cmd_ready, pdi_ready, pdo_valid
  );

endinterface

// File: rtl/remus_blkcnt_lfsr.sv
// One doubling step of the 8-bit block counter in GF(2^8).
module remus_blkcnt_lfsr
  import remus_block_sched_pkg::*;
(
  input  logic [7:0] dold,
  output logic [7:0] dnew
);

  assign dnew = {dold[6:0], 1'b0} ^ (dold[7] ? LFSR_POLY : 8'h00);

endmodule

// File: rtl/remus_block_sched.sv
// Remus block sequencer: walks the datapath through load, rounds, counter fix and unload.
module remus_block_sched
  import remus_block_sched_pkg::*;
#(
  parameter int unsigned BUSWIDTH     = BUSWIDTH_DEF,
  parameter int unsigned BUSWIDTHBYTE = BUSWIDTH / 8,
  parameter int unsigned ROUNDS       = ROUNDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  remus_block_sched_if.slave      bus,
  output logic                    srst,
  output logic                    senc,
  output logic                    sse,
  output logic                    xrst,
  output logic                    xenc,
  output logic                    xse,
  output logic                    erst,
  output logic                    sl,
  output logic                    correct_cnt,
  output logic [7:0]              dold,
  output logic [7:0]              dnew,
  output logic [BUSWIDTHBYTE-1:0] decrypt,
  output logic                    busy
);

  localparam int unsigned BEATS  = 128 / BUSWIDTH;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned RND_W  = $clog2(ROUNDS);

  sched_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic [7:0]        blk_q, blk_d;
  cmd_t              cmd_q, cmd_d;

  // Counter byte reads as its reset value while rst is held.
  assign dold = rst ? BLK_CNT_INIT : blk_q;

  remus_blkcnt_lfsr u_lfsr (
    .dold (dold),
    .dnew (dnew)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      rnd_q   <= '0;
      blk_q   <= BLK_CNT_INIT;
      cmd_q   <= CMD_RESET;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    rnd_d         = rnd_q;
    blk_d         = blk_q;
    cmd_d         = cmd_q;
    bus.cmd_ready = 1'b0;
    bus.pdi_ready = 1'b0;
    bus.pdo_valid = 1'b0;
    srst          = 1'b0;
    senc          = 1'b0;
    sse           = 1'b0;
    xrst          = 1'b0;
    xenc          = 1'b0;
    xse           = 1'b0;
    erst          = 1'b0;
    sl            = 1'b0;
    correct_cnt   = 1'b0;
    decrypt       = '0;
    busy          = 1'b0;

    if (rst) begin
      srst = 1'b1;
      xrst = 1'b1;
      erst = 1'b1;
    end else begin
      busy = (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          bus.cmd_ready = 1'b1;
          erst          = 1'b1;
          if (bus.cmd_valid) begin
            cmd_d.op     = decode_op(bus.cmd_op);
            cmd_d.nbytes = clamp_nbytes(bus.cmd_nbytes);
            beat_d       = '0;
            state_d      = ST_LOAD;
            if (bus.cmd_first) begin
              srst  = 1'b1;
              xrst  = 1'b1;
              blk_d = BLK_CNT_INIT;
            end
          end
        end

        // State and tkx shift in together, one beat per pdi handshake.
        ST_LOAD: begin
          bus.pdi_ready = 1'b1;
          erst          = 1'b1;
          if (bus.pdi_valid) begin
            senc   = 1'b1;
            sse    = 1'b1;
            xenc   = 1'b1;
            xse    = 1'b1;
            beat_d = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              beat_d  = '0;
              rnd_d   = '0;
              state_d = ST_ROUND;
            end
          end
        end

        ST_ROUND: begin
          senc  = 1'b1;
          xenc  = 1'b1;
          rnd_d = rnd_q + RND_W'(1);
          if (rnd_q == RND_W'(ROUNDS - 1)) begin
            state_d = ST_FIX;
          end
        end

        ST_FIX: begin
          correct_cnt = 1'b1;
          xenc        = 1'b1;
          blk_d       = dnew;
          beat_d      = '0;
          state_d     = (cmd_q.op == OP_AD) ? ST_IDLE : ST_OUT;
        end

        ST_OUT: begin
          bus.pdo_valid = 1'b1;
          sl            = 1'b1;
          for (int unsigned i = 0; i < BUSWIDTHBYTE; i++) begin
            decrypt[i] = (cmd_q.op == OP_DEC) &&
                         ((32'(beat_q) * BUSWIDTHBYTE + i) < 32'(cmd_q.nbytes));
          end
          if (bus.pdo_ready) begin
            senc   = 1'b1;
            sse    = 1'b1;
            beat_d = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              beat_d  = '0;
              state_d = ST_IDLE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remus_block_sched.sv
// Randomized bench for remus_block_sched: block-level reference model feeding a cycle monitor.
module tb_remus_block_sched;

  localparam int NBEATS = 4;
  localparam int NROUNDS = 40;

  typedef struct {
    logic [1:0] op;
    logic [7:0] dold;
  } blk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       srst, senc, sse, xrst, xenc, xse, erst, sl, correct_cnt, busy;
  logic [7:0] dold, dnew;
  logic [3:0] decrypt;

  remus_block_sched_if bus ();

  remus_block_sched dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .srst        (srst),
    .senc        (senc),
    .sse         (sse),
    .xrst        (xrst),
    .xenc        (xenc),
    .xse         (xse),
    .erst        (erst),
    .sl          (sl),
    .correct_cnt (correct_cnt),
    .dold        (dold),
    .dnew        (dnew),
    .decrypt     (decrypt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  blk_t       blk_q[$];
  logic [3:0] pdo_q[$];
  int         model_blk = 1;
  int         pdi_prob = 100, pdo_prob = 100;
  int         pdi_gap = 0, pdo_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiply by x modulo x^8+x^4+x^3+x^2+1.
  function automatic int gf_double(input int x);
    int y;
    y = (x * 2) % 256;
    if (x >= 128) y = y ^ 29;
    return y;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [1:0] op, input logic [4:0] nb, input int beat);
    int n, lo;
    n  = (nb == 0 || nb > 16) ? 16 : int'(nb);
    lo = 4 * beat;
    if (op != 2'd2) return 4'h0;
    if (n >= lo + 4) return 4'hF;
    if (n <= lo) return 4'h0;
    return 4'((1 << (n - lo)) - 1);
  endfunction

  // Issue one command; caller is just after a rising edge.
  task automatic issue(input logic [1:0] op, input logic first, input logic [4:0] nb);
    blk_t e;
    bit   done = 1'b0;
    if (first) model_blk = 1;
    e.op   = op;
    e.dold = 8'(model_blk);
    blk_q.push_back(e);
    if (op == 2'd1 || op == 2'd2)
      for (int b = 0; b < NBEATS; b++) pdo_q.push_back(exp_mask(op, nb, b));
    model_blk = gf_double(model_blk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_first  = first;
    bus.cmd_nbytes = nb;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      done = bus.cmd_ready;
    end
    check("cmd_handshake_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'($urandom_range(0, 3));
    bus.cmd_first  = 1'($urandom_range(0, 1));
    bus.cmd_nbytes = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = !busy;
    end
    check("idle_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Input-bus valid and output-bus ready, with optional forced gaps.
  initial begin
    bus.pdi_valid = 1'b0;
    bus.pdo_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pdi_gap > 0) begin
        bus.pdi_valid = 1'b0;
        pdi_gap--;
      end else begin
        bus.pdi_valid = ($urandom_range(0, 99) < pdi_prob);
      end
      if (pdo_gap > 0) begin
        bus.pdo_ready = 1'b0;
        pdo_gap--;
      end else begin
        bus.pdo_ready = ($urandom_range(0, 99) < pdo_prob);
      end
    end
  end

  // Cycle monitor: expected strobes follow the block phase implied by handshakes seen so far.
  int   ph = 0;
  int   nload = 0, nrnd = 0;
  bit   after_rst = 1'b0;
  blk_t cur;

  always @(negedge clk) begin
    logic e_cr, e_pr, e_pv, e_srst, e_senc, e_sse, e_xrst, e_xenc, e_xse, e_erst, e_sl, e_cc, e_busy;
    logic [3:0]  e_dec;
    logic [16:0] act;
    string       nm;
    {e_cr, e_pr, e_pv, e_srst, e_senc, e_sse, e_xrst, e_xenc, e_xse, e_erst, e_sl, e_cc, e_busy} = '0;
    e_dec = 4'h0;
    nm    = "idle_ctl";
    act = {bus.cmd_ready, bus.pdi_ready, bus.pdo_valid, srst, senc, sse, xrst, xenc, xse,
           erst, sl, correct_cnt, busy, decrypt};
    if (rst) begin
      check("reset_ctl", 32'(act), 32'({13'b0001001001000, 4'h0}));
      check("reset_dold", 32'(dold), 32'h01);
      check("reset_dnew", 32'(dnew), 32'h02);
      ph = 0;
      blk_q.delete();
      pdo_q.delete();
      after_rst = 1'b1;
    end else begin
      case (ph)
        0: begin
          e_cr   = 1'b1;
          e_erst = 1'b1;
          if (after_rst) begin
            check("post_reset_dold", 32'(dold), 32'h01);
            after_rst = 1'b0;
          end
          if (bus.cmd_valid) begin
            e_srst = bus.cmd_first;
            e_xrst = bus.cmd_first;
            check("sb_cmd_present", 32'(blk_q.size() > 0), 32'd1);
            if (blk_q.size() > 0) begin
              cur   = blk_q.pop_front();
              ph    = 1;
              nload = 0;
            end
          end
        end
        1: begin
          nm = "load_ctl";
          e_pr = 1'b1; e_erst = 1'b1; e_busy = 1'b1;
          if (bus.pdi_valid) begin
            {e_senc, e_sse, e_xenc, e_xse} = 4'hF;
            nload++;
            if (nload == NBEATS) begin
              ph   = 2;
              nrnd = 0;
            end
          end
        end
        2: begin
          nm = "round_ctl";
          e_senc = 1'b1; e_xenc = 1'b1; e_busy = 1'b1;
          nrnd++;
          if (nrnd == NROUNDS) ph = 3;
        end
        3: begin
          nm = "fix_ctl";
          e_cc = 1'b1; e_xenc = 1'b1; e_busy = 1'b1;
          check("fix_dold", 32'(dold), 32'(cur.dold));
          check("fix_dnew", 32'(dnew), 32'(gf_double(int'(cur.dold))));
          ph = (cur.op == 2'd1 || cur.op == 2'd2) ? 4 : 0;
        end
        default: begin
          nm = "out_ctl";
          e_pv = 1'b1; e_sl = 1'b1; e_busy = 1'b1;
          check("sb_pdo_present", 32'(pdo_q.size() > 0), 32'd1);
          if (pdo_q.size() > 0) e_dec = pdo_q[0];
          if (bus.pdo_ready) begin
            e_senc = 1'b1; e_sse = 1'b1;
            if (pdo_q.size() > 0) void'(pdo_q.pop_front());
            nload++;
            if (nload == 2 * NBEATS) ph = 0;
          end
        end
      endcase
      check(nm, 32'(act), 32'({e_cr, e_pr, e_pv, e_srst, e_senc, e_sse, e_xrst, e_xenc, e_xse,
                              e_erst, e_sl, e_cc, e_busy, e_dec}));
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_first  = 1'b0;
    bus.cmd_nbytes = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-block encrypt, then a short decrypt, then an AD chain through counter wrap.
    issue(2'd1, 1'b1, 5'd16);
    issue(2'd2, 1'b0, 5'd6);
    issue(2'd0, 1'b1, 5'd16);
    for (int k = 0; k < 8; k++) issue(2'd0, 1'b0, 5'(k * 3));

    // Backpressure on both buses with forced gaps.
    issue(2'd2, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    pdi_gap = 3;
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      seen = bus.pdo_valid;
    end
    check("pdo_valid_timeout", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    pdo_gap = 5;
    wait_idle();

    // Reset in the middle of the rounds, then a non-first block from a cleared counter.
    issue(2'd1, 1'b1, 5'd16);
    repeat (24) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_blk = 1;
    issue(2'd1, 1'b0, 5'd16);
    wait_idle();

    // Random traffic with stalls, reserved opcodes and out-of-range byte counts.
    pdi_prob = 70;
    pdo_prob = 60;
    for (int k = 0; k < 40; k++)
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_blk_drain", 32'(blk_q.size()), 32'd0);
    check("sb_pdo_drain", 32'(pdo_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
